serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Digit-serial subtractor: computes X - Y - bin over WIDTH bits, DIGIT bits
//   per clock, LSB first, with a registered borrow between digits. X/Y are
//   in_a/in_b, or in_b/in_a when in_mode=1. One operation takes N=WIDTH/DIGIT
//   RUN cycles followed by a single DONE cycle.
//
// Parameters
//   WIDTH  operand/result width, >= 2, multiple of DIGIT
//   DIGIT  bits processed per RUN cycle, 1..WIDTH
//
// Ports
//   in_clk      clock, rising edge
//   in_rst      asynchronous active-high reset
//   in_start    start request, honoured only in IDLE or DONE
//   in_mode     0: in_a - in_b, 1: in_b - in_a (latched at start)
//   in_a, in_b  operands (latched at start)
//   in_borrow   initial borrow-in (latched at start)
//   out_busy    high while in RUN
//   out_done    one-cycle pulse, result valid
//   out_sub     difference
//   out_borrow  final borrow-out (unsigned underflow)
//   out_zero    out_sub == 0
//   out_ovf     two's-complement overflow
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_sub,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]       x_sr;        // effective minuend, shifted right each RUN cycle
    logic [WIDTH-1:0]       y_sr;        // effective subtrahend, shifted right each RUN cycle
    logic [WIDTH-1:0]       res_sr;      // result, digits enter at the MSB end
    logic                   brw;         // borrow carried between digits
    logic [CW-1:0]          cnt;
    logic                   x_msb;       // operand sign bits, needed for overflow after shifting out
    logic                   y_msb;

    logic [DIGIT-1:0]       digit_diff;
    logic                   digit_bout;
    logic                   chain_b;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   last;
    logic                   load;

    // Ripple of full-subtract cells across the low digit.
    always_comb begin
        digit_diff = '0;
        chain_b    = brw;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            digit_diff[i] = x_sr[i] ^ y_sr[i] ^ chain_b;
            chain_b       = (~x_sr[i] & y_sr[i]) | (~(x_sr[i] ^ y_sr[i]) & chain_b);
        end
        digit_bout = chain_b;
    end

    // Concatenate-then-slice keeps the shift legal when DIGIT == WIDTH.
    assign res_cat  = {digit_diff, res_sr};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    assign last = (cnt == CW'(N - 1));
    assign load = in_start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_start) state_next = S_RUN;
            S_RUN:   if (last)     state_next = S_DONE;
            S_DONE:  state_next = in_start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign out_busy = (state == S_RUN);
    assign out_done = (state == S_DONE);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            x_sr       <= '0;
            y_sr       <= '0;
            res_sr     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            x_msb      <= 1'b0;
            y_msb      <= 1'b0;
            out_sub    <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
        end else if (load) begin
            x_sr  <= in_mode ? in_b : in_a;
            y_sr  <= in_mode ? in_a : in_b;
            x_msb <= in_mode ? in_b[WIDTH-1] : in_a[WIDTH-1];
            y_msb <= in_mode ? in_a[WIDTH-1] : in_b[WIDTH-1];
            brw   <= in_borrow;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            x_sr   <= x_sr >> DIGIT;
            y_sr   <= y_sr >> DIGIT;
            res_sr <= res_next;
            brw    <= digit_bout;
            cnt    <= cnt + CW'(1);
            if (last) begin
                out_sub    <= res_next;
                out_borrow <= digit_bout;
                out_zero   <= (res_next == '0);
                out_ovf    <= (x_msb != y_msb) && (res_next[WIDTH-1] != x_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct {
        logic [7:0]  sub;
        logic        bo;
        logic        z;
        logic        ov;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int D  = 1 << g;
        localparam int NN = 8 / D;

        logic       rst, start, mode, bin;
        logic [7:0] a, b;
        logic       busy, done, bo, zero, ovf;
        logic [7:0] sub;
        exp_t       q[$];
        exp_t       e;
        bit         fin = 1'b0;

        serial_subtractor #(.WIDTH(8), .DIGIT(D)) dut (
            .in_clk     (clk),
            .in_rst     (rst),
            .in_start   (start),
            .in_mode    (mode),
            .in_a       (a),
            .in_b       (b),
            .in_borrow  (bin),
            .out_busy   (busy),
            .out_done   (done),
            .out_sub    (sub),
            .out_borrow (bo),
            .out_zero   (zero),
            .out_ovf    (ovf)
        );

        function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
            compared++;
            if (act !== req) begin
                mismatched++;
                $display("FAIL digit%0d %s: got %0h expected %0h (t=%0t)", D, nm, act, req, $time);
            end
        endfunction

        // Reference: plain integer subtraction with one extra bit for the borrow.
        task automatic op(input logic [7:0] xa, input logic [7:0] xb, input logic m, input logic bi);
            exp_t       r;
            logic [7:0] X, Y;
            logic [8:0] d;
            int         n = 0;
            while (busy && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (busy) chk("busy_timeout", 32'(busy), 32'd0);
            X = m ? xb : xa;
            Y = m ? xa : xb;
            d = {1'b0, X} - {1'b0, Y} - 9'(bi);
            r.sub = d[7:0];
            r.bo  = d[8];
            r.z   = (d[7:0] == 8'd0);
            r.ov  = (X[7] != Y[7]) && (d[7] != X[7]);
            r.cyc = cyc + 1 + NN;
            a = xa; b = xb; mode = m; bin = bi; start = 1'b1;
            q.push_back(r);
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic drain();
            int n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                chk("drain_timeout", 32'(q.size()), 32'd0);
                q.delete();
            end
        endtask

        // Monitor: pops one expectation per done pulse.
        initial forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sub",       32'(sub),  32'(e.sub));
                    chk("borrow",    32'(bo),   32'(e.bo));
                    chk("zero",      32'(zero), 32'(e.z));
                    chk("ovf",       32'(ovf),  32'(e.ov));
                    chk("done_cyc",  cyc,       e.cyc);
                end
            end
        end

        initial begin
            int n;
            rst = 1'b1; start = 1'b0; mode = 1'b0; bin = 1'b0; a = '0; b = '0;
            repeat (3) @(negedge clk);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_sub",  32'(sub),  0);
            chk("rst_bo",   32'(bo),   0);
            chk("rst_zero", 32'(zero), 0);
            chk("rst_ovf",  32'(ovf),  0);
            rst = 1'b0;
            @(negedge clk);

            // Underflow wrap, leaves non-zero outputs for the abort check.
            op(8'h00, 8'h01, 1'b0, 1'b0);
            drain();

            // Abort mid-RUN.
            op(8'h55, 8'h22, 1'b0, 1'b0);
            repeat ((NN > 3) ? 3 : NN - 1) @(negedge clk);
            chk("pre_abort_busy", 32'(busy), 1);
            rst = 1'b1;
            void'(q.pop_back());
            @(negedge clk);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_sub",  32'(sub),  0);
            chk("abort_bo",   32'(bo),   0);
            chk("abort_zero", 32'(zero), 0);
            chk("abort_ovf",  32'(ovf),  0);
            rst = 1'b0;
            repeat (NN + 3) @(negedge clk);

            op(8'h55, 8'h22, 1'b0, 1'b0);
            op(8'h00, 8'h00, 1'b0, 1'b1);
            op(8'h80, 8'h01, 1'b0, 1'b0);
            op(8'h80, 8'h01, 1'b1, 1'b0);
            drain();

            // Back-to-back: second start lands in the DONE cycle.
            op(8'h3C, 8'h3C, 1'b0, 1'b0);
            op(8'h10, 8'h20, 1'b0, 1'b0);
            drain();

            op(8'hA7, 8'h5E, 1'b0, 1'b1);
            drain();

            // Start and operand changes during RUN must be ignored.
            op(8'hC3, 8'h17, 1'b0, 1'b0);
            start = 1'b1; a = 8'($urandom); b = 8'($urandom); mode = 1'b1; bin = 1'b1;
            chk("busy_in_run", 32'(busy), 1);
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                start = 1'b0;
                n++;
                if (done) break;
                chk("busy_hold", 32'(busy), 1);
            end
            if (n >= 50) chk("run_timeout", 32'(done), 1);
            drain();

            for (int i = 0; i < 125; i++) begin
                op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2) * NN) @(negedge clk);
            end
            drain();
            repeat (NN + 3) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (lane[0].fin && lane[1].fin && lane[2].fin && lane[3].fin);
            begin
                repeat (60000) @(posedge clk);
                compared++;
                mismatched++;
                $display("FAIL global_timeout: got running expected finished");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
